// File: rtl/gray_monitor.sv
// Checks the output of an upstream 3-bit Gray counter: decodes it, pulses on legal
// increments, counts wraps and illegal transitions, and cross-checks the overflow flag.
module gray_monitor (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [2:0] Gray,
    input  logic       Ovf,
    input  logic       Sync,
    input  logic       Clr,
    output logic [2:0] Bin,
    output logic       Step,
    output logic [7:0] Wraps,
    output logic       Err,
    output logic [3:0] ErrCnt,
    output logic       OvfErr,
    output logic       Locked
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  bin_q, bin_d;
    logic [2:0]  prev_q, prev_d;
    logic        povf_q, povf_d;
    logic        step_q, step_d;
    logic [7:0]  wraps_q, wraps_d;
    logic        err_q, err_d;
    logic [3:0]  errcnt_q, errcnt_d;
    logic        ovferr_q, ovferr_d;
    logic        wrap_seen_q, wrap_seen_d;

    logic [2:0]  cur;
    logic        is_hold;
    logic        is_inc;
    logic        is_wrap;
    logic        first_wrap;
    logic        ovf_rise;
    logic        ovf_fall;

    always_comb begin
        cur        = {Gray[2], Gray[2] ^ Gray[1], Gray[2] ^ Gray[1] ^ Gray[0]};
        is_hold    = (cur == prev_q);
        is_inc     = (prev_q != 3'd7) && (cur == prev_q + 3'd1);
        is_wrap    = (prev_q == 3'd7) && (cur == 3'd0);
        first_wrap = is_wrap && !wrap_seen_q;
        ovf_rise   = Ovf && !povf_q;
        ovf_fall   = !Ovf && povf_q;
    end

    always_comb begin
        bin_d       = cur;
        prev_d      = cur;
        povf_d      = Ovf;
        state_d     = state_q;
        step_d      = 1'b0;
        wraps_d     = wraps_q;
        err_d       = err_q;
        errcnt_d    = errcnt_q;
        ovferr_d    = ovferr_q;
        wrap_seen_d = wrap_seen_q;

        if (Clr) begin
            state_d     = ST_IDLE;
            wraps_d     = '0;
            err_d       = 1'b0;
            errcnt_d    = '0;
            ovferr_d    = 1'b0;
            wrap_seen_d = 1'b0;
        end else if (Sync) begin
            // Upstream restarted: re-acquire without judging this sample.
            state_d     = ST_IDLE;
            wrap_seen_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_LOCK;
                    wrap_seen_d = 1'b0;
                end
                ST_LOCK, ST_FAULT: begin
                    if (is_hold) begin
                        step_d = 1'b0;
                    end else if (is_inc) begin
                        step_d = 1'b1;
                    end else if (is_wrap) begin
                        step_d      = 1'b1;
                        wrap_seen_d = 1'b1;
                        if (wraps_q != 8'hFF) begin
                            wraps_d = wraps_q + 8'd1;
                        end
                    end else begin
                        state_d = ST_FAULT;
                        err_d   = 1'b1;
                        if (errcnt_q != 4'hF) begin
                            errcnt_d = errcnt_q + 4'd1;
                        end
                    end
                    // Ovf must rise exactly at the first wrap after acquisition and never fall.
                    if ((ovf_rise && !first_wrap) || (first_wrap && !Ovf) || ovf_fall) begin
                        ovferr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            prev_q      <= '0;
            povf_q      <= 1'b0;
            step_q      <= 1'b0;
            wraps_q     <= '0;
            err_q       <= 1'b0;
            errcnt_q    <= '0;
            ovferr_q    <= 1'b0;
            wrap_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            prev_q      <= prev_d;
            povf_q      <= povf_d;
            step_q      <= step_d;
            wraps_q     <= wraps_d;
            err_q       <= err_d;
            errcnt_q    <= errcnt_d;
            ovferr_q    <= ovferr_d;
            wrap_seen_q <= wrap_seen_d;
        end
    end

    assign Bin    = bin_q;
    assign Step   = step_q;
    assign Wraps  = wraps_q;
    assign Err    = err_q;
    assign ErrCnt = errcnt_q;
    assign OvfErr = ovferr_q;
    assign Locked = (state_q == ST_LOCK);

endmodule
